// File: rtl/conv_pkg.sv
// Shared constants for the convolution datapath: feature-map geometry,
// requantization shift, output width and derived pooled-coordinate widths.
package conv_pkg;

  localparam int FMAP_H  = 26;   // rows per column, even
  localparam int FMAP_W  = 26;   // columns per frame, even
  localparam int SHIFT   = 12;   // fraction bits of the weights
  localparam int OUT_W   = 16;   // output data width
  localparam int IN_W    = 32;   // conv result width

  // Largest value representable on the non-negative output range.
  localparam int SAT_MAX = (1 << (OUT_W - 1)) - 1;

  // Widths of the pooled row/column indices.
  localparam int PROW_W  = $clog2(FMAP_H / 2);
  localparam int PCOL_W  = $clog2(FMAP_W / 2);

endpackage

// File: rtl/relu_requant.sv
// Stage 1: ReLU, arithmetic right shift and saturation of one conv result,
// registered together with its valid flag and row/column tags.
module relu_requant #(
  parameter int SHIFT = conv_pkg::SHIFT,
  parameter int OUT_W = conv_pkg::OUT_W,
  parameter int RW    = 5,
  parameter int CW    = 5
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clr,
  input  logic                    in_valid,
  input  logic signed [31:0]      in_data,
  input  logic        [RW-1:0]    in_r,
  input  logic        [CW-1:0]    in_c,
  output logic                    q_valid,
  output logic        [OUT_W-1:0] q_data,
  output logic        [RW-1:0]    q_r,
  output logic        [CW-1:0]    q_c
);

  localparam logic [31:0]      SAT_MAX32 = 32'((64'd1 << (OUT_W - 1)) - 64'd1);
  localparam logic [OUT_W-1:0] SAT_Q     = SAT_MAX32[OUT_W-1:0];

  logic signed [31:0] shifted;
  logic [OUT_W-1:0]   q_next;

  // Clamp negatives to zero, otherwise shift and saturate to the output range.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    q_next  = '0;
    shifted = in_data >>> SHIFT;
    if (in_data[31]) begin
      q_next = '0;
    end else if (shifted > $signed(SAT_MAX32)) begin
      q_next = SAT_Q;
    end else begin
      q_next = shifted[OUT_W-1:0];
    end
  end

  // Stage-1 register; clr drops the in-flight sample and the one arriving with it.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state is updated with <= so every register samples pre-edge values.
    if (!reset_n) begin
      q_valid <= 1'b0;
      q_data  <= '0;
      q_r     <= '0;
      q_c     <= '0;
    end else if (clr) begin
      q_valid <= 1'b0;
    end else begin
      q_valid <= in_valid;
      if (in_valid) begin
        q_data <= q_next;
        q_r    <= in_r;
        q_c    <= in_c;
      end
    end
  end

endmodule

// File: rtl/relu_pool_stage.sv
// ReLU + requantize + 2x2/stride-2 max pooling over a column-major stream
// of conv results. One sample per cycle, no backpressure.
module relu_pool_stage #(
  parameter int FMAP_H = conv_pkg::FMAP_H,
  parameter int FMAP_W = conv_pkg::FMAP_W,
  parameter int SHIFT  = conv_pkg::SHIFT,
  parameter int OUT_W  = conv_pkg::OUT_W
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              clr,
  input  logic                              in_valid,
  input  logic signed [31:0]                in_data,
  output logic                              out_valid,
  output logic [OUT_W-1:0]                  out_data,
  output logic [$clog2(FMAP_H/2)-1:0]       out_row,
  output logic [$clog2(FMAP_W/2)-1:0]       out_col,
  output logic                              frame_done
);

  localparam int RW   = $clog2(FMAP_H);
  localparam int CW   = $clog2(FMAP_W);
  localparam int PRW  = $clog2(FMAP_H / 2);
  localparam int PCW  = $clog2(FMAP_W / 2);
  localparam int LB_D = FMAP_H / 2;

  localparam logic [RW-1:0] R_LAST = RW'(FMAP_H - 1);
  localparam logic [CW-1:0] C_LAST = CW'(FMAP_W - 1);

  logic [RW-1:0]    r_cnt;
  logic [CW-1:0]    c_cnt;

  logic             q_valid;
  logic [OUT_W-1:0] q_data;
  logic [RW-1:0]    q_r;
  logic [CW-1:0]    q_c;

  logic [OUT_W-1:0] pair_reg;
  logic [OUT_W-1:0] linebuf [LB_D];
  logic [PRW-1:0]   lb_idx;
  logic [OUT_W-1:0] pm;
  logic [OUT_W-1:0] pool_max;
  logic             fire;
  logic             last_win;

  // Column-major position counters: row advances per accepted sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      c_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
      c_cnt <= '0;
    end else if (in_valid) begin
      if (r_cnt == R_LAST) begin
        r_cnt <= '0;
        c_cnt <= (c_cnt == C_LAST) ? '0 : c_cnt + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  relu_requant #(
    .SHIFT (SHIFT),
    .OUT_W (OUT_W),
    .RW    (RW),
    .CW    (CW)
  ) u_requant (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (clr),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_r     (r_cnt),
    .in_c     (c_cnt),
    .q_valid  (q_valid),
    .q_data   (q_data),
    .q_r      (q_r),
    .q_c      (q_c)
  );

  // Row-pair max, column-pair max against the line buffer, and output strobes.
  always_comb begin
    lb_idx   = PRW'(q_r >> 1);
    pm       = (q_data > pair_reg) ? q_data : pair_reg;
    pool_max = (pm > linebuf[lb_idx]) ? pm : linebuf[lb_idx];
    fire     = q_valid && q_r[0] && q_c[0];
    last_win = (q_r == R_LAST) && (q_c == C_LAST);
  end

  // Pairing storage: even rows park in pair_reg, even columns park row maxima.
  always_ff @(posedge clk) begin
    // NOTE: the line buffer is not reset; every entry is written before it is read.
    if (q_valid && !clr) begin
      if (!q_r[0]) begin
        pair_reg <= q_data;
      end else if (!q_c[0]) begin
        linebuf[lb_idx] <= pm;
      end
    end
  end

  // Output register: one pooled result per completed 2x2 window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_row    <= '0;
      out_col    <= '0;
      frame_done <= 1'b0;
    end else if (clr) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= fire;
      frame_done <= fire && last_win;
      if (fire) begin
        out_data <= pool_max;
        out_row  <= PRW'(q_r >> 1);
        out_col  <= PCW'(q_c >> 1);
      end
    end
  end

endmodule
